// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, companion of the UART transmit module.
//
// The asynchronous line is brought into the clock domain through a two-flop
// synchronizer. The start bit is confirmed at its centre, and each data bit
// and the stop bit are then sampled one full bit period apart, so every
// sample lands near the middle of its bit.
//
// Parameters:
//   CLKS_PER_BIT  system clocks per bit period (8..65535); must match the
//                 transmitter so the two can be looped back on-chip.
//
// Ports:
//   i_Clock     system clock, rising edge
//   i_Reset     synchronous active-high reset, also aborts a frame in flight
//   i_UART      asynchronous serial line, idle high
//   o_Data      last correctly framed byte (LSB arrives first)
//   o_Valid     one-cycle pulse when o_Data is updated
//   o_FrameErr  one-cycle pulse when the stop bit samples low
//   o_Busy      high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int CLKS_PER_BIT = 104
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_UART,
    output logic [7:0] o_Data,
    output logic       o_Valid,
    output logic       o_FrameErr,
    output logic       o_Busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int H     = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(H);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic             sync_r;
    logic             rx_s;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] clk_cnt_r;
    logic [CNT_W-1:0] clk_cnt_nxt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic [7:0]       data_nxt_s;
    logic             valid_nxt_s;
    logic             ferr_nxt_s;

    // Next-state and next-output logic of the receive FSM.
    always_comb begin
        state_nxt_s   = state_r;
        clk_cnt_nxt_s = clk_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        data_nxt_s    = o_Data;
        valid_nxt_s   = 1'b0;
        ferr_nxt_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                bit_idx_nxt_s = 3'd0;
                if (rx_s == 1'b0) begin
                    // The cycle that first sees the low line is already the
                    // first cycle of the start bit, so START begins at one.
                    state_nxt_s   = ST_START;
                    clk_cnt_nxt_s = CNT_ONE;
                end else begin
                    state_nxt_s   = ST_IDLE;
                    clk_cnt_nxt_s = CNT_ZERO;
                end
            end

            ST_START: begin
                if (clk_cnt_r == CNT_HALF) begin
                    clk_cnt_nxt_s = CNT_ZERO;
                    bit_idx_nxt_s = 3'd0;
                    // A line that is high again at mid start bit was a glitch.
                    if (rx_s == 1'b0) begin
                        state_nxt_s = ST_DATA;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (clk_cnt_r == CNT_LAST) begin
                    clk_cnt_nxt_s          = CNT_ZERO;
                    shift_nxt_s[bit_idx_r] = rx_s;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (clk_cnt_r == CNT_LAST) begin
                    clk_cnt_nxt_s = CNT_ZERO;
                    // Returning to IDLE at mid stop bit leaves half a bit to
                    // catch a start bit that follows with no idle gap.
                    if (rx_s == 1'b1) begin
                        data_nxt_s  = shift_r;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        ferr_nxt_s  = 1'b1;
                        state_nxt_s = ST_BREAK;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_ONE;
                end
            end

            ST_BREAK: begin
                // Hold off until the line recovers so a long low never
                // looks like a fresh start bit.
                clk_cnt_nxt_s = CNT_ZERO;
                if (rx_s == 1'b1) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end

            default: begin
                state_nxt_s   = ST_IDLE;
                clk_cnt_nxt_s = CNT_ZERO;
                bit_idx_nxt_s = 3'd0;
            end
        endcase
    end

    // Synchronizer, FSM state, counters and registered outputs.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            sync_r     <= 1'b1;
            rx_s       <= 1'b1;
            state_r    <= ST_IDLE;
            clk_cnt_r  <= CNT_ZERO;
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
            o_Data     <= 8'h00;
            o_Valid    <= 1'b0;
            o_FrameErr <= 1'b0;
            o_Busy     <= 1'b0;
        end else begin
            sync_r     <= i_UART;
            rx_s       <= sync_r;
            state_r    <= state_nxt_s;
            clk_cnt_r  <= clk_cnt_nxt_s;
            bit_idx_r  <= bit_idx_nxt_s;
            shift_r    <= shift_nxt_s;
            o_Data     <= data_nxt_s;
            o_Valid    <= valid_nxt_s;
            o_FrameErr <= ferr_nxt_s;
            o_Busy     <= (state_nxt_s != ST_IDLE);
        end
    end

endmodule
